// File: rtl/idct1d.sv
// 8-point 1-D inverse DCT: serial Q8 multiply-accumulate over a write-once
// coefficient buffer, results held in an 8-entry buffer read through oe/add.
module idct1d #(
    parameter int n = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr,
    input  logic [2:0]          add,
    input  logic signed [n-1:0] data_in,
    input  logic                start,
    input  logic                oe,
    output logic                busy,
    output logic                done,
    output logic signed [n-1:0] data_out
);

    localparam int AW = n + 13;
    localparam int PW = n + 9;
    localparam logic signed [AW-1:0] MAX_V = AW'(2**(n-1) - 1);
    localparam logic signed [AW-1:0] MIN_V = -MAX_V - AW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic signed [n-1:0]  coef [8];
    logic signed [n-1:0]  y    [8];
    logic [2:0]           k, i;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] rounded;
    logic signed [PW-1:0] product;
    logic signed [8:0]    tval;
    logic signed [n-1:0]  result;

    // cos(m*pi/16) folded onto the first quadrant; k=0 carries the 1/sqrt(2) weight.
    function automatic logic signed [8:0] cos_q8(input logic [2:0] kk, input logic [2:0] ii);
        logic [5:0]        m6;
        logic [5:0]        m;
        logic [5:0]        r;
        logic              neg;
        logic [7:0]        mag;
        logic signed [8:0] t;
        m6  = {2'b00, ii, 1'b1} * {3'b000, kk};
        m   = m6 & 6'b011111;
        r   = m;
        neg = 1'b0;
        if (r > 6'd16) begin
            r = 6'd32 - r;
        end
        if (r > 6'd8) begin
            r   = 6'd16 - r;
            neg = 1'b1;
        end
        case (r)
            6'd0:    mag = 8'd128;
            6'd1:    mag = 8'd126;
            6'd2:    mag = 8'd118;
            6'd3:    mag = 8'd106;
            6'd4:    mag = 8'd91;
            6'd5:    mag = 8'd71;
            6'd6:    mag = 8'd49;
            6'd7:    mag = 8'd25;
            default: mag = 8'd0;
        endcase
        if (kk == 3'd0) begin
            mag = 8'd91;
        end
        t = $signed({1'b0, mag});
        if (neg) begin
            t = -t;
        end
        return t;
    endfunction

    always_comb begin
        tval    = cos_q8(k, i);
        product = PW'(coef[k]) * PW'(tval);
        sum     = acc + AW'(product);
        rounded = (sum + AW'(128)) >>> 8;
        if (rounded > MAX_V) begin
            result = {1'b0, {(n-1){1'b1}}};
        end else if (rounded < MIN_V) begin
            result = {1'b1, {(n-1){1'b0}}};
        end else begin
            result = rounded[n-1:0];
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (k == 3'd7 && i == 3'd7) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The result of row i is committed on its eighth MAC, using the sum that
    // includes that final product, so the accumulator restarts at zero for row i+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            acc      <= '0;
            k        <= '0;
            i        <= '0;
            data_out <= '0;
            for (int j = 0; j < 8; j++) begin
                coef[j] <= '0;
                y[j]    <= '0;
            end
        end else begin
            state <= state_next;
            if (state == S_IDLE && wr) begin
                coef[add] <= data_in;
            end
            if (oe) begin
                data_out <= y[add];
            end
            if (state == S_IDLE && start) begin
                k   <= '0;
                i   <= '0;
                acc <= '0;
            end else if (state == S_COMPUTE) begin
                k <= k + 3'd1;
                if (k == 3'd7) begin
                    y[i] <= result;
                    acc  <= '0;
                    i    <= i + 3'd1;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

endmodule
